// File: rtl/bcd_key_entry_if.sv
// Key-entry handshake and converter-side bus for bcd_key_entry.
// The keypad source is the master; the entry stage is the slave.
interface bcd_key_entry_if;
  logic       i_key_valid;
  logic [3:0] i_key_code;
  logic       o_key_ready;
  logic [3:0] o_hundreds;
  logic [3:0] o_tens;
  logic [3:0] o_ones;
  logic       o_is_signed;
  logic       o_ce;
  logic       o_a;
  logic       o_b;
  logic [1:0] o_count;
  logic       o_done;
  logic       o_err;

  modport master (
    output i_key_valid, i_key_code,
    input  o_key_ready, o_hundreds, o_tens, o_ones, o_is_signed,
           o_ce, o_a, o_b, o_count, o_done, o_err
  );

  modport slave (
    input  i_key_valid, i_key_code,
    output o_key_ready, o_hundreds, o_tens, o_ones, o_is_signed,
           o_ce, o_a, o_b, o_count, o_done, o_err
  );
endinterface

// File: rtl/bcd_key_entry.sv
// Keypad operand entry: assembles two signed 3-digit BCD operands (A then B)
// and sequences the downstream BCD-to-binary converter load strobes.
//
// state    | meaning
// ENTRY_A  | collecting digits/sign of operand A, ready for keys
// COMMIT_A | converter enabled for COMMIT_CYC cycles, o_a on the last one
// ENTRY_B  | collecting digits/sign of operand B, ready for keys
// COMMIT_B | converter enabled for COMMIT_CYC cycles, o_b on the last one
// DONE     | both operands loaded; a digit starts a new operand A
module bcd_key_entry #(
  parameter int NDIG       = 3,
  parameter int COMMIT_CYC = 3
) (
  input logic            CLK,
  input logic            RST_N,
  bcd_key_entry_if.slave kif
);

  localparam int CW = $clog2(COMMIT_CYC + 1);
  localparam logic [CW-1:0] CYC_INIT = CW'(COMMIT_CYC - 1);

  localparam logic [3:0] KEY_NEG   = 4'd10;
  localparam logic [3:0] KEY_BKSP  = 4'd11;
  localparam logic [3:0] KEY_ENTER = 4'd12;
  localparam logic [3:0] KEY_CLEAR = 4'd13;

  typedef enum logic [2:0] {
    ENTRY_A  = 3'd0,
    COMMIT_A = 3'd1,
    ENTRY_B  = 3'd2,
    COMMIT_B = 3'd3,
    DONE     = 3'd4
  } state_t;

  state_t        state_q;
  logic [3:0]    hund_q, tens_q, ones_q;
  logic          sign_q;
  logic [1:0]    count_q;
  logic          ce_q, a_q, b_q, done_q, err_q, ready_q;
  logic [CW-1:0] cyc_q;

  logic       key_acc;
  logic [3:0] code;
  logic       is_digit;

  assign key_acc  = kif.i_key_valid & ready_q;
  assign code     = kif.i_key_code;
  assign is_digit = (code <= 4'd9);

  // Entry/commit sequencer; every output is a register so the converter
  // sees glitch-free strobes.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ENTRY_A;
      hund_q  <= '0;
      tens_q  <= '0;
      ones_q  <= '0;
      sign_q  <= 1'b0;
      count_q <= '0;
      ce_q    <= 1'b0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
      cyc_q   <= '0;
    end else begin
      err_q <= 1'b0;
      case (state_q)
        ENTRY_A, ENTRY_B: begin
          if (key_acc) begin
            if (is_digit) begin
              if (count_q != NDIG[1:0]) begin
                hund_q  <= tens_q;
                tens_q  <= ones_q;
                ones_q  <= code;
                count_q <= count_q + 2'd1;
              end else begin
                err_q <= 1'b1;
              end
            end else begin
              case (code)
                KEY_NEG: sign_q <= ~sign_q;
                KEY_BKSP: begin
                  if (count_q != 2'd0) begin
                    ones_q  <= tens_q;
                    tens_q  <= hund_q;
                    hund_q  <= '0;
                    count_q <= count_q - 2'd1;
                  end else begin
                    err_q <= 1'b1;
                  end
                end
                KEY_ENTER: begin
                  state_q <= (state_q == ENTRY_A) ? COMMIT_A : COMMIT_B;
                  ready_q <= 1'b0;
                  ce_q    <= 1'b1;
                  cyc_q   <= CYC_INIT;
                  a_q     <= (CYC_INIT == '0) && (state_q == ENTRY_A);
                  b_q     <= (CYC_INIT == '0) && (state_q == ENTRY_B);
                end
                KEY_CLEAR: begin
                  state_q <= ENTRY_A;
                  hund_q  <= '0;
                  tens_q  <= '0;
                  ones_q  <= '0;
                  sign_q  <= 1'b0;
                  count_q <= '0;
                end
                default: err_q <= 1'b1;
              endcase
            end
          end
        end
        COMMIT_A, COMMIT_B: begin
          if (cyc_q != '0) begin
            cyc_q <= cyc_q - CW'(1);
            a_q   <= (cyc_q == CW'(1)) && (state_q == COMMIT_A);
            b_q   <= (cyc_q == CW'(1)) && (state_q == COMMIT_B);
          end else begin
            ce_q    <= 1'b0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            hund_q  <= '0;
            tens_q  <= '0;
            ones_q  <= '0;
            sign_q  <= 1'b0;
            count_q <= '0;
            ready_q <= 1'b1;
            if (state_q == COMMIT_A) begin
              state_q <= ENTRY_B;
            end else begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end
          end
        end
        DONE: begin
          if (key_acc) begin
            if (is_digit) begin
              state_q <= ENTRY_A;
              ones_q  <= code;
              count_q <= 2'd1;
              done_q  <= 1'b0;
            end else if (code == KEY_CLEAR) begin
              state_q <= ENTRY_A;
              done_q  <= 1'b0;
            end else if (code > KEY_CLEAR) begin
              err_q <= 1'b1;
            end
          end
        end
        default: state_q <= ENTRY_A;
      endcase
    end
  end

  assign kif.o_key_ready = ready_q;
  assign kif.o_hundreds  = hund_q;
  assign kif.o_tens      = tens_q;
  assign kif.o_ones      = ones_q;
  assign kif.o_is_signed = sign_q;
  assign kif.o_ce        = ce_q;
  assign kif.o_a         = a_q;
  assign kif.o_b         = b_q;
  assign kif.o_count     = count_q;
  assign kif.o_done      = done_q;
  assign kif.o_err       = err_q;

endmodule

// File: tb/tb_bcd_key_entry.sv
// Bench for bcd_key_entry: directed scenarios then random key traffic,
// every cycle compared against an arithmetic model of the operand entry.
module tb_bcd_key_entry;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  bcd_key_entry_if kif();

  bcd_key_entry #(.NDIG(3), .COMMIT_CYC(3)) dut (
    .CLK   (clk),
    .RST_N (rst_n),
    .kif   (kif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: phase 0 entry A, 1 commit A, 2 entry B, 3 commit B, 4 done
  int m_phase, m_v, m_n, m_k;
  bit m_sign, m_ce, m_a, m_b, m_ready, m_done, m_err;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = 0; m_v = 0; m_n = 0; m_k = 0;
    m_sign = 0; m_ce = 0; m_a = 0; m_b = 0;
    m_ready = 1; m_done = 0; m_err = 0;
  endtask

  task automatic model_update(input bit v, input logic [3:0] c);
    bit acc;
    acc   = v && m_ready;
    m_err = 0;
    case (m_phase)
      1, 3: begin
        if (m_k < 3) begin
          m_k++;
          m_a = (m_phase == 1) && (m_k == 3);
          m_b = (m_phase == 3) && (m_k == 3);
        end else begin
          m_ce = 0; m_a = 0; m_b = 0;
          m_v = 0; m_n = 0; m_sign = 0; m_k = 0;
          m_ready = 1;
          if (m_phase == 1) m_phase = 2;
          else begin
            m_phase = 4;
            m_done  = 1;
          end
        end
      end
      0, 2: if (acc) begin
        if (c <= 9) begin
          if (m_n < 3) begin
            m_v = m_v * 10 + int'(c);
            m_n++;
          end else m_err = 1;
        end else if (c == 10) m_sign = !m_sign;
        else if (c == 11) begin
          if (m_n > 0) begin
            m_v = m_v / 10;
            m_n--;
          end else m_err = 1;
        end else if (c == 12) begin
          m_phase = m_phase + 1;
          m_k = 1; m_ce = 1; m_ready = 0;
        end else if (c == 13) begin
          m_v = 0; m_n = 0; m_sign = 0; m_phase = 0;
        end else m_err = 1;
      end
      default: if (acc) begin
        if (c <= 9) begin
          m_phase = 0; m_v = int'(c); m_n = 1; m_done = 0;
        end else if (c == 13) begin
          m_phase = 0; m_done = 0;
        end else if (c >= 14) m_err = 1;
      end
    endcase
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".ready"}, 16'(kif.o_key_ready), 16'(m_ready));
    chk({tag, ".hund"},  16'(kif.o_hundreds),  16'(m_v / 100));
    chk({tag, ".tens"},  16'(kif.o_tens),      16'((m_v / 10) % 10));
    chk({tag, ".ones"},  16'(kif.o_ones),      16'(m_v % 10));
    chk({tag, ".sign"},  16'(kif.o_is_signed), 16'(m_sign));
    chk({tag, ".ce"},    16'(kif.o_ce),        16'(m_ce));
    chk({tag, ".a"},     16'(kif.o_a),         16'(m_a));
    chk({tag, ".b"},     16'(kif.o_b),         16'(m_b));
    chk({tag, ".count"}, 16'(kif.o_count),     16'(m_n));
    chk({tag, ".done"},  16'(kif.o_done),      16'(m_done));
    chk({tag, ".err"},   16'(kif.o_err),       16'(m_err));
  endtask

  task automatic step(input string tag, input bit v, input logic [3:0] c);
    kif.i_key_valid = v;
    kif.i_key_code  = c;
    @(posedge clk);
    model_update(v, c);
    #1 check_all(tag);
  endtask

  task automatic key(input string tag, input logic [3:0] c);
    step(tag, 1'b1, c);
    step(tag, 1'b0, 4'd0);
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 4'd0);
  endtask

  // Asynchronous reset asserted between edges; outputs must fall at once.
  task automatic apply_reset(input string tag);
    #2 rst_n = 1'b0;
    kif.i_key_valid = 1'b0;
    kif.i_key_code  = 4'd0;
    model_reset();
    #1 check_all(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    kif.i_key_valid = 1'b0;
    kif.i_key_code  = 4'd0;
    model_reset();
    #12 check_all("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // 1) three digits, fourth rejected
    key("t1", 4'd1); key("t1", 4'd2); key("t1", 4'd3);
    chk("t1.hund_const", 16'(kif.o_hundreds), 16'd1);
    chk("t1.ones_const", 16'(kif.o_ones), 16'd3);
    step("t1_4th", 1'b1, 4'd4);
    chk("t1.err_const", 16'(kif.o_err), 16'd1);
    step("t1_4th", 1'b0, 4'd0);
    chk("t1.err_drop", 16'(kif.o_err), 16'd0);

    // 2) clear, 4,5, backspace, backspace x2 with second rejected
    key("t2", 4'd13);
    key("t2", 4'd4); key("t2", 4'd5); key("t2", 4'd11);
    chk("t2.ones_const", 16'(kif.o_ones), 16'd4);
    key("t2", 4'd11);
    step("t2_bk0", 1'b1, 4'd11);
    chk("t2.err_const", 16'(kif.o_err), 16'd1);
    step("t2", 1'b0, 4'd0);

    // 3) A = -125, commit
    key("t3", 4'd1); key("t3", 4'd2); key("t3", 4'd5); key("t3", 4'd10);
    step("t3_enter", 1'b1, 4'd12);
    idle("t3_commit", 4);
    chk("t3.entry_b_ready", 16'(kif.o_key_ready), 16'd1);

    // 4) B = 7, commit, done
    key("t4", 4'd7);
    step("t4_enter", 1'b1, 4'd12);
    idle("t4_commit", 4);
    chk("t4.done_const", 16'(kif.o_done), 16'd1);
    key("t4_done_ign", 4'd12); key("t4_done_ign", 4'd10); key("t4_done_ign", 4'd11);
    key("t4_done_err", 4'd15);

    // 5) ENTER held valid through the commit of A, then taken as B=000
    key("t5", 4'd9);
    for (int i = 0; i < 6; i++) step("t5_held", 1'b1, 4'd12);
    idle("t5", 5);
    key("t5_newa", 4'd3);

    // 6) reset during the second commit cycle
    step("t6_enter", 1'b1, 4'd12);
    step("t6_c2", 1'b0, 4'd0);
    apply_reset("t6_rst");
    idle("t6_after", 2);

    // random traffic, digit-heavy, occasional reset
    for (int i = 0; i < 3000; i++) begin
      int r;
      logic [3:0] c;
      r = int'($urandom_range(0, 99));
      if (r < 55)      c = 4'($urandom_range(0, 9));
      else if (r < 65) c = 4'd10;
      else if (r < 75) c = 4'd11;
      else if (r < 88) c = 4'd12;
      else if (r < 93) c = 4'd13;
      else             c = 4'($urandom_range(14, 15));
      if ($urandom_range(0, 499) == 0) apply_reset("rnd_rst");
      step("rnd", 1'($urandom_range(0, 1)), c);
    end

    kif.i_key_valid = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
